alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the ALU control decoder.
- Consumes the 3-bit ALU control code plus operands and produces result, zero and overflow under a start/busy/done handshake.
- AND/OR/ADD/SUB/SLT finish in one cycle.
- SLL/SRL use a serial shifter that moves one bit per cycle. This replaces a barrel shifter and keeps area low.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W >= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy==0.
- alu_ctr  input  3  operation code from the ALU control decoder.
- op_a  input  WIDTH  operand A (rs).
- op_b  input  WIDTH  operand B (rt or immediate); also the shift source.
- shamt  input  SHAMT_W  shift amount, used only for SLL/SRL.
- busy  output  1  high while an operation is in flight (SHIFT or DONE state).
- done  output  1  one-cycle pulse; result, zero and overflow are valid from this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  registered, (result == 0).
- overflow  output  1  registered signed overflow; ADD/SUB only, 0 for all other ops.

Behaviour:
- alu_ctr encoding is fixed:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT
  - 011 SLL
  - 100 SRL
  - 101 reserved
- Reset (async, rst_n=0): state=IDLE; busy, done, result, zero, overflow and the shift counter all = 0. Reset mid-shift aborts the operation with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 samples all inputs.
  - Non-shift op, or shift with shamt==0: compute into result/zero/overflow, go to DONE.
  - Shift with shamt>0: acc<=op_b, cnt<=shamt, go to SHIFT.
  - start=0: stay in IDLE, outputs hold.
- SHIFT:
  - Each cycle acc shifts by 1. SLL inserts 0 at the LSB; SRL is a logical shift inserting 0 at the MSB.
  - cnt decrements each cycle.
  - When cnt==1 the final shift is written to result, zero is updated, and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency from the start edge to the done cycle:
  - 1 cycle for non-shift ops and for shamt==0.
  - shamt+1 cycles for shifts.
  - Minimum issue interval is 2 cycles.
- start while busy=1 is ignored: no queueing, and the in-flight operands are not disturbed.
- Operand capture: inputs may change after the accept edge without affecting the in-flight op.
- Arithmetic:
  - ADD/SUB wrap modulo 2**WIDTH.
  - overflow = signed overflow: for ADD, operands of equal sign and a result of differing sign; for SUB, operands of differing sign and result sign different from op_a.
- SLT: signed compare, result = {0..0, (op_a <s op_b)}. No overflow artefact; compare correctly even when a-b overflows.
- shamt >= WIDTH is not reachable with the defaults. If the parameters allow it, the result is 0.
- Reserved code 101: result=0, zero=1, overflow=0, 1-cycle latency, normal done.
- Outputs hold their last value from done until the next accepted op completes. Only done pulses.

Decomposition:
- Shared package alu_pkg holds:
  - localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111, ALU_SLL=3'b011, ALU_SRL=3'b100.
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module alu_logic_core: purely combinational. Takes alu_ctr, a and b; returns value and ovf for AND/OR/ADD/SUB/SLT/reserved.
- The top level owns the FSM, the shift accumulator/counter and the output registers.

Test Plan:
- ADD: a=0x7FFFFFFF, b=1, start 1 cycle -> done exactly 1 cycle later; result=0x80000000, overflow=1, zero=0, busy high for 1 cycle.
- SUB: a=5, b=5 -> result=0, zero=1, overflow=0. SLT: a=0x80000000, b=1 -> result=1; SLT a=1, b=0x80000000 -> result=0.
- SLL: b=0x00000001, shamt=31 -> done 32 cycles after start, result=0x80000000. SRL: b=0x80000000, shamt=4 -> done at 5 cycles, result=0x08000000. shamt=0 -> done at 1 cycle, result=b.
- Pulse start with different operands during a shift -> ignored; original result unchanged, exactly one done. Start in IDLE the cycle after done -> accepted.
- Assert rst_n=0 mid-SLL (cycle 3 of 10) -> immediately busy=0, result=0, no done. After release, a new AND a=0xF0F0F0F0, b=0xFF00FF00 -> result=0xF000F000.
- AND/OR sweep plus reserved code 101 -> result=0, zero=1, done after 1 cycle; outputs hold across idle cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and helpers for the ALU execute stage.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] ctr);
    return (ctr == ALU_SLL) || (ctr == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Single-cycle combinational ALU ops; shift and reserved codes yield zero.
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  assign sum  = a + b;
  assign diff = a - b;
  // Direct signed compare, so SLT is immune to a-b overflow.
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    value = '0;
    ovf   = 1'b0;
    case (alu_ctr)
      ALU_AND: value = a & b;
      ALU_OR:  value = a | b;
      ALU_ADD: begin
        value = sum;
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        value = diff;
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: value = WIDTH'(lt);
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: one-cycle logic/arith ops, serial one-bit-per-cycle shifts.
//   state    | meaning
//   ST_IDLE  | waiting for start, outputs hold
//   ST_SHIFT | serial shift in progress, cnt_q shifts remain
//   ST_DONE  | done pulse, outputs valid
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         alu_ctr,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 left_q, left_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH-1:0]     shifted;
  logic [WIDTH-1:0]     core_value;
  logic                 core_ovf;
  logic                 accept;
  logic                 serial_req;
  logic                 last_shift;

  alu_logic_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctr (alu_ctr),
    .a       (op_a),
    .b       (op_b),
    .value   (core_value),
    .ovf     (core_ovf)
  );

  assign accept     = (state_q == ST_IDLE) && start;
  assign serial_req = is_shift_op(alu_ctr) && (shamt != '0);
  assign last_shift = (state_q == ST_SHIFT) && (cnt_q == SHAMT_W'(1));
  assign shifted    = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = serial_req ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Result registers only change when an op completes, so outputs hold otherwise.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    if (accept) begin
      if (serial_req) begin
        acc_d  = op_b;
        cnt_d  = shamt;
        left_d = (alu_ctr == ALU_SLL);
      end else if (is_shift_op(alu_ctr)) begin
        result_d = op_b;
        zero_d   = (op_b == '0);
        ovf_d    = 1'b0;
      end else begin
        result_d = core_value;
        zero_d   = (core_value == '0);
        ovf_d    = core_ovf;
      end
    end else if (state_q == ST_SHIFT) begin
      acc_d = shifted;
      cnt_d = cnt_q - SHAMT_W'(1);
      if (last_shift) begin
        result_d = shifted;
        zero_d   = (shifted == '0);
        ovf_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule
